// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants for the 7-segment scan decoder: active-low glyphs and slot helpers.
package seg_scan_decoder_pkg;

    localparam int unsigned DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic is_onehot_low(logic [3:0] an_n);
        return $countones(~an_n) == 1;
    endfunction

    function automatic logic [1:0] slot_idx(logic [3:0] an_n);
        logic [1:0] idx;
        case (an_n)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Display-side pins and reconstructed frame outputs of the scan decoder.
interface seg_scan_decoder_if;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic [15:0] value_out;
    logic [3:0]  dp_out;
    logic [3:0]  err_out;
    logic        frame_done;
    logic        stale;

    modport master (
        output seg, an, dp,
        input  value_out, dp_out, err_out, frame_done, stale
    );

    modport slave (
        input  seg, an, dp,
        output value_out, dp_out, err_out, frame_done, stale
    );
endinterface

// File: rtl/seg7_to_hex.sv
// Active-low 7-segment glyph to hex nibble; unknown patterns (incl. blank) flag err and read 0.
module seg7_to_hex
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       err_o
);

    always_comb begin
        nibble_o = 4'h0;
        err_o    = 1'b0;
        case (seg_i)
            SEG_0:   nibble_o = 4'h0;
            SEG_1:   nibble_o = 4'h1;
            SEG_2:   nibble_o = 4'h2;
            SEG_3:   nibble_o = 4'h3;
            SEG_4:   nibble_o = 4'h4;
            SEG_5:   nibble_o = 4'h5;
            SEG_6:   nibble_o = 4'h6;
            SEG_7:   nibble_o = 4'h7;
            SEG_8:   nibble_o = 4'h8;
            SEG_9:   nibble_o = 4'h9;
            SEG_A:   nibble_o = 4'hA;
            SEG_B:   nibble_o = 4'hB;
            SEG_C:   nibble_o = 4'hC;
            SEG_D:   nibble_o = 4'hD;
            SEG_E:   nibble_o = 4'hE;
            SEG_F:   nibble_o = 4'hF;
            default: err_o    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a scanned 4-digit 7-segment display, qualifies each digit for stability and
// publishes a coherent 16-bit frame once every slot has been captured.
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned TIMEOUT       = 1 << 20
) (
    input  logic         mclk,
    input  logic         reset_n,
    seg_scan_decoder_if.slave bus
);

    localparam int unsigned CntW   = $clog2(STABLE_CYCLES);
    localparam int unsigned StaleW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0]   CntCap   = CntW'(STABLE_CYCLES - 1);
    localparam logic [CntW-1:0]   CntPre   = CntW'(STABLE_CYCLES - 2);
    localparam logic [StaleW-1:0] StaleMax = StaleW'(TIMEOUT);

    logic [3:0]          an_q, an_prev_q;
    logic [6:0]          seg_q, seg_prev_q;
    logic                dp_q, dp_prev_q;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DIGITS-1:0]   mask_q, mask_d;
    logic [4*DIGITS-1:0] hold_val_q, hold_val_d;
    logic [DIGITS-1:0]   hold_dp_q, hold_dp_d;
    logic [DIGITS-1:0]   hold_err_q, hold_err_d;
    logic [4*DIGITS-1:0] value_q;
    logic [DIGITS-1:0]   dp_out_q, err_q;
    logic                frame_done_q;
    logic [StaleW-1:0]   stale_cnt_q, stale_cnt_d;

    logic       hit, cap, frame;
    logic [1:0] idx;
    logic [3:0] nib;
    logic       seg_err;

    seg7_to_hex u_dec (
        .seg_i    (seg_q),
        .nibble_o (nib),
        .err_o    (seg_err)
    );

    always_comb begin
        hit   = is_onehot_low(an_q) && ({an_q, seg_q, dp_q} == {an_prev_q, seg_prev_q, dp_prev_q});
        // Capture only on the transition into CntCap; saturation blocks recapture.
        cap   = hit && (cnt_q == CntPre);
        frame = &mask_q;
        idx   = slot_idx(an_q);

        cnt_d = '0;
        if (hit) begin
            cnt_d = (cnt_q == CntCap) ? cnt_q : cnt_q + 1'b1;
        end

        mask_d     = frame ? '0 : mask_q;
        hold_val_d = hold_val_q;
        hold_dp_d  = hold_dp_q;
        hold_err_d = hold_err_q;
        if (cap) begin
            mask_d[idx]            = 1'b1;
            hold_val_d[4*idx +: 4] = nib;
            hold_dp_d[idx]         = ~dp_q;
            hold_err_d[idx]        = seg_err;
        end

        stale_cnt_d = stale_cnt_q;
        if (cap) begin
            stale_cnt_d = '0;
        end else if (stale_cnt_q != StaleMax) begin
            stale_cnt_d = stale_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            an_q         <= 4'hF;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            an_prev_q    <= 4'hF;
            seg_prev_q   <= SEG_BLANK;
            dp_prev_q    <= 1'b1;
            cnt_q        <= '0;
            mask_q       <= '0;
            hold_val_q   <= '0;
            hold_dp_q    <= '0;
            hold_err_q   <= '0;
            value_q      <= '0;
            dp_out_q     <= '0;
            err_q        <= '0;
            frame_done_q <= 1'b0;
            stale_cnt_q  <= '0;
        end else begin
            an_q         <= bus.an;
            seg_q        <= bus.seg;
            dp_q         <= bus.dp;
            an_prev_q    <= an_q;
            seg_prev_q   <= seg_q;
            dp_prev_q    <= dp_q;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            hold_val_q   <= hold_val_d;
            hold_dp_q    <= hold_dp_d;
            hold_err_q   <= hold_err_d;
            frame_done_q <= frame;
            stale_cnt_q  <= stale_cnt_d;
            if (frame) begin
                value_q  <= hold_val_q;
                dp_out_q <= hold_dp_q;
                err_q    <= hold_err_q;
            end
        end
    end

    assign bus.value_out  = value_q;
    assign bus.dp_out     = dp_out_q;
    assign bus.err_out    = err_q;
    assign bus.frame_done = frame_done_q;
    assign bus.stale      = (stale_cnt_q == StaleMax);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: table of full scans plus hand-written corner sequences.
module tb_seg_scan_decoder;

    localparam int unsigned STABLE = 4;
    localparam int unsigned TMO    = 64;
    localparam int          LAT    = 1 + STABLE + 1;

    typedef struct packed {
        logic [27:0] segs;   // {d3, d2, d1, d0}
        logic [3:0]  dp_n;
        logic [15:0] exp_val;
        logic [3:0]  exp_dp;
        logic [3:0]  exp_err;
    } vec_t;

    logic mclk;
    logic reset_n;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   fd_cnt = 0;
    vec_t vecs[7];

    seg_scan_decoder_if bus ();

    seg_scan_decoder #(
        .STABLE_CYCLES (STABLE),
        .TIMEOUT       (TMO)
    ) dut (
        .mclk    (mclk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    always @(negedge mclk) begin
        if (bus.frame_done) fd_cnt <= fd_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.an  = 4'hF;
        bus.seg = 7'h7F;
        bus.dp  = 1'b1;
        tick(n);
    endtask

    task automatic scan(input logic [27:0] segs, input logic [3:0] dp_n, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.an  = ~(4'b0001 << i);
            bus.seg = segs[7*i +: 7];
            bus.dp  = dp_n[i];
            tick(8);
        end
    endtask

    initial begin
        int fd0;
        logic [15:0] held;

        vecs[0] = '{{7'h79, 7'h08, 7'h24, 7'h0E}, 4'hF,    16'h1A2F, 4'h0,    4'h0};
        vecs[1] = '{{7'h40, 7'h79, 7'h24, 7'h30}, 4'hF,    16'h0123, 4'h0,    4'h0};
        vecs[2] = '{{7'h19, 7'h12, 7'h02, 7'h78}, 4'b0110, 16'h4567, 4'b1001, 4'h0};
        vecs[3] = '{{7'h00, 7'h10, 7'h08, 7'h03}, 4'hF,    16'h89AB, 4'h0,    4'h0};
        vecs[4] = '{{7'h46, 7'h21, 7'h06, 7'h0E}, 4'hF,    16'hCDEF, 4'h0,    4'h0};
        vecs[5] = '{{7'h79, 7'h7F, 7'h24, 7'h30}, 4'b1110, 16'h1023, 4'b0001, 4'b0100};
        vecs[6] = '{{7'h40, 7'h40, 7'h7E, 7'h00}, 4'hF,    16'h0008, 4'h0,    4'b0010};

        reset_n = 1'b0;
        bus.an  = 4'hF;
        bus.seg = 7'h7F;
        bus.dp  = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(2);
        chk("rst_value", 32'(bus.value_out), 32'h0);
        chk("rst_dp", 32'(bus.dp_out), 32'h0);
        chk("rst_err", 32'(bus.err_out), 32'h0);
        chk("rst_fd", 32'(bus.frame_done), 32'h0);
        chk("rst_stale", 32'(bus.stale), 32'h0);

        // Full scans, one frame each
        for (int v = 0; v < 7; v++) begin
            fd0 = fd_cnt;
            scan(vecs[v].segs, vecs[v].dp_n, 0, 3);
            idle(2);
            chk($sformatf("v%0d_fd", v), 32'(fd_cnt - fd0), 32'd1);
            chk($sformatf("v%0d_value", v), 32'(bus.value_out), 32'(vecs[v].exp_val));
            chk($sformatf("v%0d_dp", v), 32'(bus.dp_out), 32'(vecs[v].exp_dp));
            chk($sformatf("v%0d_err", v), 32'(bus.err_out), 32'(vecs[v].exp_err));
        end

        // Short hold on the last slot must not capture; mask survives, then exact latency
        held = bus.value_out;
        fd0  = fd_cnt;
        scan({7'h78, 7'h06, 7'h30, 7'h10}, 4'hF, 0, 2);
        bus.an  = 4'b0111;
        bus.seg = 7'h78;
        tick(STABLE - 1);
        idle(10);
        chk("short_fd", 32'(fd_cnt - fd0), 32'd0);
        chk("short_value", 32'(bus.value_out), 32'(held));
        bus.an  = 4'b0111;
        bus.seg = 7'h78;
        tick(LAT - 1);
        chk("lat_early", 32'(bus.frame_done), 32'h0);
        tick(1);
        chk("lat_pulse", 32'(bus.frame_done), 32'h1);
        tick(1);
        chk("lat_one_cycle", 32'(bus.frame_done), 32'h0);
        chk("lat_value", 32'(bus.value_out), 32'h7E39);
        idle(2);

        // Two anodes low at once: nothing captured
        fd0     = fd_cnt;
        bus.an  = 4'b0011;
        bus.seg = 7'h00;
        tick(20);
        chk("overlap_fd", 32'(fd_cnt - fd0), 32'd0);
        scan({7'h40, 7'h40, 7'h40, 7'h00}, 4'hF, 0, 3);
        idle(2);
        chk("after_overlap_fd", 32'(fd_cnt - fd0), 32'd1);
        chk("after_overlap_value", 32'(bus.value_out), 32'h0008);

        // Stale after TMO idle cycles; first capture clears it
        fd0 = fd_cnt;
        idle(30);
        chk("stale_early", 32'(bus.stale), 32'h0);
        idle(40);
        chk("stale_set", 32'(bus.stale), 32'h1);
        chk("stale_value_held", 32'(bus.value_out), 32'h0008);
        chk("stale_no_fd", 32'(fd_cnt - fd0), 32'd0);
        bus.an  = 4'b1110;
        bus.seg = 7'h79;
        bus.dp  = 1'b1;
        tick(STABLE + 2);
        chk("stale_cleared", 32'(bus.stale), 32'h0);

        // Reset mid-frame discards partial captures
        scan({7'h03, 7'h06, 7'h06, 7'h0E}, 4'hF, 0, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_value", 32'(bus.value_out), 32'h0);
        chk("midrst_dp", 32'(bus.dp_out), 32'h0);
        chk("midrst_err", 32'(bus.err_out), 32'h0);
        chk("midrst_stale", 32'(bus.stale), 32'h0);
        idle(2);
        reset_n = 1'b1;
        idle(2);
        fd0 = fd_cnt;
        scan({7'h03, 7'h06, 7'h06, 7'h0E}, 4'hF, 2, 3);
        idle(2);
        chk("postrst_partial_fd", 32'(fd_cnt - fd0), 32'd0);
        scan({7'h03, 7'h06, 7'h06, 7'h0E}, 4'hF, 0, 1);
        idle(2);
        chk("postrst_fd", 32'(fd_cnt - fd0), 32'd1);
        chk("postrst_value", 32'(bus.value_out), 32'hBEEF);
        chk("postrst_err", 32'(bus.err_out), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
